// File: rtl/decoder2x4_hold.sv
// ---------------------------------------------------------------------------
// decoder2x4_hold
//
// Registered 2-to-4 decoder with a per-code hold timer. A valid-qualified
// 2-bit code (from a 4-to-2 priority encoder's {Q1,Q0}/v outputs) drives the
// matching one-hot line for HOLD cycles. While a line is held, one further
// code can wait in a single-entry pending buffer. Codes that arrive while the
// buffer is full are dropped and flagged on overrun.
//
// Parameters:
//   HOLD      cycles each decoded line stays asserted (1..255)
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   in_valid  code qualifier
//   in_code   encoded index; code k selects y[k]
//   in_ready  block can accept a code this cycle
//   y         one-hot decoded output, all-zero when idle
//   busy      a line is currently held
//   overrun   high in the cycle a presented code is dropped
//
// Optional feature (macro DECODER2X4_MERGE_EN):
//   When defined, a code equal to the line currently held restarts the hold
//   timer instead of being queued. It is accepted even if the pending buffer
//   is full.
// ---------------------------------------------------------------------------
module decoder2x4_hold #(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] in_code,
    output logic       in_ready,
    output logic [3:0] y,
    output logic       busy,
    output logic       overrun
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    // The counter runs from HOLD-1 down to 0, which gives exactly HOLD cycles.
    localparam logic [7:0] RELOAD = 8'(HOLD - 1);

    logic [0:0] state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [3:0] y_reg, y_next;
    logic [1:0] pend_code_reg, pend_code_next;
    logic       pend_valid_reg, pend_valid_next;

    logic [3:0] dec_in;
    logic [3:0] dec_pend;
    logic       merge_hit;
    logic       accept;

    // One-hot decode of the incoming code and of the pending code.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_decode
            assign dec_in[gi]   = (in_code == 2'(gi));
            assign dec_pend[gi] = (pend_code_reg == 2'(gi));
        end
    endgenerate

`ifdef DECODER2X4_MERGE_EN
    // y_reg is one-hot while holding, so an overlap with the decoded input
    // means the incoming code matches the held line.
    assign merge_hit = (state_reg == S_HOLD) && ((y_reg & dec_in) != 4'b0000);
`else
    assign merge_hit = 1'b0;
`endif

    assign in_ready = !pend_valid_reg || merge_hit;
    assign accept   = in_valid && in_ready;
    assign overrun  = in_valid && !in_ready;
    assign busy     = (state_reg == S_HOLD);
    assign y        = y_reg;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        y_next          = y_reg;
        pend_code_next  = pend_code_reg;
        pend_valid_next = pend_valid_reg;

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    y_next     = dec_in;
                    cnt_next   = RELOAD;
                    state_next = S_HOLD;
                end
            end
            default: begin
                if (accept && merge_hit) begin
                    // Same code again: stretch the current pulse.
                    cnt_next = RELOAD;
                end else if (cnt_reg != 8'd0) begin
                    cnt_next = cnt_reg - 8'd1;
                    if (accept) begin
                        pend_code_next  = in_code;
                        pend_valid_next = 1'b1;
                    end
                end else if (pend_valid_reg) begin
                    y_next          = dec_pend;
                    cnt_next        = RELOAD;
                    pend_valid_next = 1'b0;
                end else if (accept) begin
                    // Bypass the empty buffer so back-to-back codes leave no gap.
                    y_next   = dec_in;
                    cnt_next = RELOAD;
                end else begin
                    y_next     = 4'b0000;
                    state_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= 8'd0;
            y_reg          <= 4'b0000;
            pend_code_reg  <= 2'b00;
            pend_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            y_reg          <= y_next;
            pend_code_reg  <= pend_code_next;
            pend_valid_reg <= pend_valid_next;
        end
    end

endmodule

// File: tb/tb_decoder2x4_hold.sv
module tb_decoder2x4_hold;

    typedef struct {
        logic       rst;
        logic       v;
        logic [1:0] c;
        logic [3:0] y;
        logic       rdy;
        logic       ov;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // HOLD = 4 instance
    logic       in_valid = 1'b0;
    logic [1:0] in_code = 2'b00;
    logic       in_ready;
    logic [3:0] y;
    logic       busy;
    logic       overrun;

    // HOLD = 1 instance
    logic       in_valid1 = 1'b0;
    logic [1:0] in_code1 = 2'b00;
    logic       in_ready1;
    logic [3:0] y1;
    logic       busy1;
    logic       overrun1;

    int errors = 0;
    int checks = 0;

    vec_t vecs[$];

    decoder2x4_hold #(.HOLD(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_code  (in_code),
        .in_ready (in_ready),
        .y        (y),
        .busy     (busy),
        .overrun  (overrun)
    );

    decoder2x4_hold #(.HOLD(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid1),
        .in_code  (in_code1),
        .in_ready (in_ready1),
        .y        (y1),
        .busy     (busy1),
        .overrun  (overrun1)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic v, input logic [1:0] c,
                       input logic [3:0] ey, input logic erdy, input logic eov,
                       input string nm);
        vec_t t;
        t.rst = r; t.v = v; t.c = c; t.y = ey; t.rdy = erdy; t.ov = eov; t.name = nm;
        vecs.push_back(t);
    endtask

    task automatic check(input string nm,
                         input logic [3:0] ay, input logic ab, input logic ardy, input logic aov,
                         input logic [3:0] ey, input logic erdy, input logic eov);
        logic eb;
        eb = (ey != 4'b0000);
        checks++;
        if (ay !== ey || ab !== eb || ardy !== erdy || aov !== eov) begin
            errors++;
            $display("FAIL %s: got y=%b busy=%b rdy=%b ovr=%b, want y=%b busy=%b rdy=%b ovr=%b",
                     nm, ay, ab, ardy, aov, ey, eb, erdy, eov);
        end else begin
            $display("ok   %s: y=%b busy=%b rdy=%b ovr=%b", nm, ay, ab, ardy, aov);
        end
    endtask

    initial begin
        // Each row: inputs for this cycle, outputs expected before the edge.
        // Reset state
        add(0, 0, 0, 4'b0000, 1, 0, "reset_state");
        // Single code 2, held 4 cycles
        add(0, 1, 2, 4'b0000, 1, 0, "single_accept");
        add(0, 0, 0, 4'b0100, 1, 0, "single_h1");
        add(0, 0, 0, 4'b0100, 1, 0, "single_h2");
        add(0, 0, 0, 4'b0100, 1, 0, "single_h3");
        add(0, 0, 0, 4'b0100, 1, 0, "single_h4");
        add(0, 0, 0, 4'b0000, 1, 0, "single_idle");
        // Codes 0..3 as soon as ready, contiguous pulses
        add(0, 1, 0, 4'b0000, 1, 0, "seq_acc0");
        add(0, 1, 1, 4'b0001, 1, 0, "seq_y0_1");
        add(0, 0, 0, 4'b0001, 0, 0, "seq_y0_2");
        add(0, 0, 0, 4'b0001, 0, 0, "seq_y0_3");
        add(0, 0, 0, 4'b0001, 0, 0, "seq_y0_4");
        add(0, 1, 2, 4'b0010, 1, 0, "seq_y1_1");
        add(0, 0, 0, 4'b0010, 0, 0, "seq_y1_2");
        add(0, 0, 0, 4'b0010, 0, 0, "seq_y1_3");
        add(0, 0, 0, 4'b0010, 0, 0, "seq_y1_4");
        add(0, 1, 3, 4'b0100, 1, 0, "seq_y2_1");
        add(0, 0, 0, 4'b0100, 0, 0, "seq_y2_2");
        add(0, 0, 0, 4'b0100, 0, 0, "seq_y2_3");
        add(0, 0, 0, 4'b0100, 0, 0, "seq_y2_4");
        add(0, 0, 0, 4'b1000, 1, 0, "seq_y3_1");
        add(0, 0, 0, 4'b1000, 1, 0, "seq_y3_2");
        add(0, 0, 0, 4'b1000, 1, 0, "seq_y3_3");
        add(0, 0, 0, 4'b1000, 1, 0, "seq_y3_4");
        add(0, 0, 0, 4'b0000, 1, 0, "seq_idle");
        // Queue then overrun
        add(0, 1, 1, 4'b0000, 1, 0, "ovr_acc1");
        add(0, 1, 3, 4'b0010, 1, 0, "ovr_queue3");
        add(0, 1, 0, 4'b0010, 0, 1, "ovr_drop0");
        add(0, 0, 0, 4'b0010, 0, 0, "ovr_h3");
        add(0, 0, 0, 4'b0010, 0, 0, "ovr_h4");
        add(0, 0, 0, 4'b1000, 1, 0, "ovr_q_1");
        add(0, 0, 0, 4'b1000, 1, 0, "ovr_q_2");
        add(0, 0, 0, 4'b1000, 1, 0, "ovr_q_3");
        add(0, 0, 0, 4'b1000, 1, 0, "ovr_q_4");
        add(0, 0, 0, 4'b0000, 1, 0, "ovr_idle");
        // Reset mid-hold with a pending code
        add(0, 1, 1, 4'b0000, 1, 0, "rst_acc1");
        add(0, 1, 2, 4'b0010, 1, 0, "rst_queue2");
        add(1, 0, 0, 4'b0010, 0, 0, "rst_assert");
        add(0, 0, 0, 4'b0000, 1, 0, "rst_after");
        add(0, 0, 0, 4'b0000, 1, 0, "rst_nopend1");
        add(0, 0, 0, 4'b0000, 1, 0, "rst_nopend2");
        add(0, 0, 0, 4'b0000, 1, 0, "rst_nopend3");
        // Same code re-presented in hold cycle 3
        add(0, 1, 2, 4'b0000, 1, 0, "same_acc2");
        add(0, 0, 0, 4'b0100, 1, 0, "same_h1");
        add(0, 0, 0, 4'b0100, 1, 0, "same_h2");
        add(0, 1, 2, 4'b0100, 1, 0, "same_h3_again");
`ifdef DECODER2X4_MERGE_EN
        add(0, 0, 0, 4'b0100, 1, 0, "merge_h4");
        add(0, 0, 0, 4'b0100, 1, 0, "merge_h5");
        add(0, 0, 0, 4'b0100, 1, 0, "merge_h6");
        add(0, 0, 0, 4'b0100, 1, 0, "merge_h7");
        add(0, 0, 0, 4'b0000, 1, 0, "merge_idle");
`else
        add(0, 0, 0, 4'b0100, 0, 0, "queue_h4");
        add(0, 0, 0, 4'b0100, 1, 0, "queue_r1");
        add(0, 0, 0, 4'b0100, 1, 0, "queue_r2");
        add(0, 0, 0, 4'b0100, 1, 0, "queue_r3");
        add(0, 0, 0, 4'b0100, 1, 0, "queue_r4");
        add(0, 0, 0, 4'b0000, 1, 0, "queue_idle");
`endif

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            rst      = vecs[i].rst;
            in_valid = vecs[i].v;
            in_code  = vecs[i].c;
            @(negedge clk);
            check(vecs[i].name, y, busy, in_ready, overrun, vecs[i].y, vecs[i].rdy, vecs[i].ov);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        in_valid = 1'b0;

        // HOLD = 1: a new code every cycle, bypass path each time
        for (int k = 0; k < 4; k++) begin
            logic [3:0] ey;
            ey = (k == 0) ? 4'b0000 : (4'b0001 << (k - 1));
            in_valid1 = 1'b1;
            in_code1  = 2'(k);
            @(negedge clk);
            check($sformatf("h1_code%0d", k), y1, busy1, in_ready1, overrun1, ey, 1'b1, 1'b0);
            @(posedge clk);
            #1;
        end
        in_valid1 = 1'b0;
        @(negedge clk);
        check("h1_last", y1, busy1, in_ready1, overrun1, 4'b1000, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("h1_idle", y1, busy1, in_ready1, overrun1, 4'b0000, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
